// File: rtl/common_pkg.sv
// Purpose: shared link-layer types, 8b/10b K-symbol codes and TX scheduler state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package common_pkg;

  // LTSSM link state as seen by the data-link layer.
  typedef enum logic [2:0] {
    RESET_state   = 3'd0,
    DISABLE_state = 3'd1,
    ACTIVE_state  = 3'd2,
    L0s_state     = 3'd3,
    RETRAIN_state = 3'd4
  } state_t;

  localparam logic [7:0] K_SDP = 8'h5C;
  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_END = 8'hFD;
  localparam logic [7:0] K_EDB = 8'hFE;

  localparam int DLLP_BYTES = 6;

  // Each state names what the lane presents in that cycle.
  typedef enum logic [2:0] {
    TX_IDLE,
    TX_D_SDP,
    TX_D_BODY,
    TX_T_STP,
    TX_T_BODY,
    TX_T_LAST,
    TX_END,
    TX_EDB
  } tx_sched_state_t;

  // Byte idx of a captured DLLP, byte 0 in bits [7:0].
  function automatic logic [7:0] dllp_byte(input logic [47:0] d, input logic [2:0] idx);
    return d[int'(idx)*8 +: 8];
  endfunction

endpackage

// File: rtl/pcie_l0s_idle_timer.sv
// Purpose: saturating idle counter that requests L0s entry once IDLE_CYCLES qualifying cycles elapse.
// Latency: l0s_req is high from the cycle after the IDLE_CYCLES-th counted cycle; drops the cycle after clr.
// Backpressure: none; clr has priority over count_en.
// Ports: pclk/reset_n clock and async active-low reset; count_en counts a qualifying cycle;
//        clr zeroes the counter; l0s_req is high while the counter is saturated.
module pcie_l0s_idle_timer #(
  parameter int IDLE_CYCLES = 64
) (
  input  logic pclk,
  input  logic reset_n,
  input  logic count_en,
  input  logic clr,
  output logic l0s_req
);

  localparam int CNT_W = $clog2(IDLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IDLE_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (count_en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign l0s_req = (cnt_q == CNT_MAX);

endmodule

// File: rtl/pcie_tx_scheduler.sv
// Purpose: shares the PIPE TX byte lane between DLLP and TLP sources, framing with SDP/STP..END/EDB.
// Latency: start token on tx_data one cycle after the grant; a TLP byte consumed in cycle n shows in n+1.
// Backpressure: dllp_ready pulses on grant; tlp_ready is high in T_STP/T_BODY, and a missing byte there aborts with EDB.
// Ports: pclk/reset_n clock and async active-low reset; link_state gates grants;
//        dllp_* 48-bit DLLP request/accept; tlp_* byte stream with last flag;
//        tx_data/tx_datak/tx_valid registered lane outputs; underrun_err, l0s_req, busy status.
module pcie_tx_scheduler
  import common_pkg::*;
#(
  parameter int DLLP_BURST_MAX  = 4,
  parameter int L0S_IDLE_CYCLES = 64
) (
  input  logic        pclk,
  input  logic        reset_n,
  input  state_t      link_state,
  input  logic        dllp_valid,
  input  logic [47:0] dllp_data,
  output logic        dllp_ready,
  input  logic        tlp_valid,
  input  logic [7:0]  tlp_data,
  input  logic        tlp_last,
  output logic        tlp_ready,
  output logic [7:0]  tx_data,
  output logic        tx_datak,
  output logic        tx_valid,
  output logic        underrun_err,
  output logic        l0s_req,
  output logic        busy
);

  localparam int STREAK_W = $clog2(DLLP_BURST_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(DLLP_BURST_MAX);
  localparam logic [2:0] LAST_IDX = 3'(DLLP_BYTES - 1);

  tx_sched_state_t state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic [47:0]         dllp_q, dllp_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_datak_q, tx_datak_d;
  logic                tx_valid_q, tx_valid_d;
  logic                underrun_q, underrun_d;

  logic link_active, link_kill, arb_slot, grant_dllp, grant_tlp, idle_qual;

  always_comb begin
    link_active = (link_state == ACTIVE_state);
    // RESET/DISABLE abandon the packet at once; L0s/RETRAIN only block new grants.
    link_kill   = (link_state == RESET_state) || (link_state == DISABLE_state);
    // END and EDB arbitrate like IDLE so packets can run back to back.
    arb_slot    = (state_q == TX_IDLE) || (state_q == TX_END) || (state_q == TX_EDB);
    grant_dllp  = arb_slot && link_active && dllp_valid &&
                  !(tlp_valid && (streak_q == STREAK_MAX));
    grant_tlp   = arb_slot && link_active && tlp_valid && !grant_dllp;
    idle_qual   = (state_q == TX_IDLE) && link_active && !dllp_valid && !tlp_valid;
  end

  // reset_n gating keeps the accept pulse low while reset is held.
  assign dllp_ready = grant_dllp && reset_n;
  assign tlp_ready  = ((state_q == TX_T_STP) || (state_q == TX_T_BODY)) && !link_kill;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    dllp_d   = dllp_q;
    streak_d = streak_q;
    if (link_kill) begin
      state_d = TX_IDLE;
      idx_d   = '0;
      dllp_d  = '0;
    end else begin
      case (state_q)
        TX_IDLE, TX_END, TX_EDB: begin
          if (grant_dllp) begin
            state_d = TX_D_SDP;
            dllp_d  = dllp_data;
            if (streak_q != STREAK_MAX) streak_d = streak_q + 1'b1;
          end else if (grant_tlp) begin
            state_d  = TX_T_STP;
            streak_d = '0;
          end else begin
            state_d = TX_IDLE;
          end
        end
        TX_D_SDP: begin
          state_d = TX_D_BODY;
          idx_d   = '0;
        end
        TX_D_BODY: begin
          if (idx_q == LAST_IDX) state_d = TX_END;
          else                   idx_d   = idx_q + 3'd1;
        end
        TX_T_STP, TX_T_BODY: begin
          if (!tlp_valid)    state_d = TX_EDB;
          else if (tlp_last) state_d = TX_T_LAST;
          else               state_d = TX_T_BODY;
        end
        TX_T_LAST: state_d = TX_END;
        default:   state_d = TX_IDLE;
      endcase
    end
  end

  // Lane outputs are registered from the next state, so tx_* always matches state_q.
  always_comb begin
    tx_data_d  = 8'h00;
    tx_datak_d = 1'b0;
    underrun_d = 1'b0;
    case (state_d)
      TX_D_SDP:  begin tx_data_d = K_SDP; tx_datak_d = 1'b1; end
      TX_D_BODY: tx_data_d = dllp_byte(dllp_d, idx_d);
      TX_T_STP:  begin tx_data_d = K_STP; tx_datak_d = 1'b1; end
      // Both are only entered on a consumed byte, so tlp_data is that byte.
      TX_T_BODY, TX_T_LAST: tx_data_d = tlp_data;
      TX_END:    begin tx_data_d = K_END; tx_datak_d = 1'b1; end
      TX_EDB:    begin tx_data_d = K_EDB; tx_datak_d = 1'b1; underrun_d = 1'b1; end
      default:   tx_data_d = 8'h00;
    endcase
    tx_valid_d = (state_d != TX_IDLE);
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= TX_IDLE;
      idx_q      <= '0;
      dllp_q     <= '0;
      streak_q   <= '0;
      tx_data_q  <= '0;
      tx_datak_q <= 1'b0;
      tx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      dllp_q     <= dllp_d;
      streak_q   <= streak_d;
      tx_data_q  <= tx_data_d;
      tx_datak_q <= tx_datak_d;
      tx_valid_q <= tx_valid_d;
      underrun_q <= underrun_d;
    end
  end

  assign tx_data      = tx_data_q;
  assign tx_datak     = tx_datak_q;
  assign tx_valid     = tx_valid_q;
  assign underrun_err = underrun_q;
  assign busy         = (state_q != TX_IDLE);

  pcie_l0s_idle_timer #(
    .IDLE_CYCLES(L0S_IDLE_CYCLES)
  ) u_l0s_timer (
    .pclk    (pclk),
    .reset_n (reset_n),
    .count_en(idle_qual),
    .clr     (!idle_qual),
    .l0s_req (l0s_req)
  );

endmodule

// File: tb/tb_pcie_tx_scheduler.sv
`timescale 1ns/1ps
module tb_pcie_tx_scheduler;
  import common_pkg::*;

  logic        pclk = 1'b0;
  logic        reset_n = 1'b0;
  state_t      link_state = RESET_state;
  logic        dllp_valid = 1'b0;
  logic [47:0] dllp_data = '0;
  logic        dllp_ready;
  logic        tlp_valid = 1'b0;
  logic [7:0]  tlp_data = '0;
  logic        tlp_last = 1'b0;
  logic        tlp_ready;
  logic [7:0]  tx_data;
  logic        tx_datak, tx_valid, underrun_err, l0s_req, busy;

  int checks = 0;
  int failures = 0;

  logic [8:0]  exp_q[$];     // {k, data} expected on the lane
  logic [47:0] dllp_src[$];
  logic [8:0]  tlp_src[$];   // {last, data}
  logic        mon_en = 1'b0;

  always #5 pclk = ~pclk;

  pcie_tx_scheduler #(.DLLP_BURST_MAX(4), .L0S_IDLE_CYCLES(64)) dut (
    .pclk(pclk), .reset_n(reset_n), .link_state(link_state),
    .dllp_valid(dllp_valid), .dllp_data(dllp_data), .dllp_ready(dllp_ready),
    .tlp_valid(tlp_valid), .tlp_data(tlp_data), .tlp_last(tlp_last), .tlp_ready(tlp_ready),
    .tx_data(tx_data), .tx_datak(tx_datak), .tx_valid(tx_valid),
    .underrun_err(underrun_err), .l0s_req(l0s_req), .busy(busy)
  );

  task automatic push_dllp_exp(input logic [47:0] d);
    exp_q.push_back({1'b1, K_SDP});
    for (int b = 0; b < 6; b++) exp_q.push_back({1'b0, d[b*8 +: 8]});
    exp_q.push_back({1'b1, K_END});
  endtask

  // Source model: accepts are sampled mid-cycle, queues advance just after the edge.
  task automatic source_driver();
    logic dtake, ttake;
    forever begin
      @(negedge pclk);
      dtake = dllp_ready && dllp_valid;
      ttake = tlp_ready && tlp_valid;
      @(posedge pclk);
      #1;
      if (dtake && dllp_src.size() > 0) dllp_src.delete(0);
      if (ttake && tlp_src.size() > 0) tlp_src.delete(0);
      dllp_valid = (dllp_src.size() > 0);
      dllp_data  = dllp_valid ? dllp_src[0] : '0;
      tlp_valid  = (tlp_src.size() > 0);
      tlp_data   = tlp_valid ? tlp_src[0][7:0] : '0;
      tlp_last   = tlp_valid ? tlp_src[0][8] : 1'b0;
    end
  endtask

  task automatic lane_monitor();
    logic [8:0] e;
    forever begin
      @(negedge pclk);
      if (mon_en && tx_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL lane_unexpected got k=%b data=%h expected nothing", tx_datak, tx_data);
        end else begin
          e = exp_q.pop_front();
          if ({tx_datak, tx_data} !== e)  begin
            failures++;
            $display("FAIL lane_byte got k=%b data=%h expected k=%b data=%h", tx_datak, tx_data, e[8], e[7:0]);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge pclk);
    checks++; if ({tx_valid, tx_datak, tx_data} !== 10'd0) begin failures++; $display("FAIL reset_lane got %b/%b/%h expected 0", tx_valid, tx_datak, tx_data); end
    checks++; if ({busy, underrun_err, l0s_req} !== 3'b000) begin failures++; $display("FAIL reset_status got %b expected 000", {busy, underrun_err, l0s_req}); end
    checks++; if ({dllp_ready, tlp_ready} !== 2'b00) begin failures++; $display("FAIL reset_ready got %b expected 00", {dllp_ready, tlp_ready}); end
    @(posedge pclk); #1;
    reset_n = 1'b1;
    link_state = ACTIVE_state;
    @(negedge pclk);
    checks++; if ({busy, tx_valid} !== 2'b00) begin failures++; $display("FAIL post_reset_idle got %b expected 00", {busy, tx_valid}); end
    mon_en = 1'b1;
  endtask

  task automatic test_single_dllp();
    int rdy_cnt = 0, rdy_at = -1, tx_first = -1, tx_cnt = 0;
    push_dllp_exp(48'h665544332211);
    @(negedge pclk);
    dllp_src.push_back(48'h665544332211);
    for (int i = 0; i < 20; i++) begin
      @(negedge pclk);
      if (dllp_ready) begin rdy_cnt++; rdy_at = i; end
      if (tx_valid) begin tx_cnt++; if (tx_first < 0) tx_first = i; end
    end
    checks++; if (rdy_cnt !== 1) begin failures++; $display("FAIL dllp_ready_pulses got %0d expected 1", rdy_cnt); end
    checks++; if (tx_first - rdy_at !== 1) begin failures++; $display("FAIL dllp_latency got %0d expected 1", tx_first - rdy_at); end
    checks++; if (tx_cnt !== 8) begin failures++; $display("FAIL dllp_length got %0d expected 8", tx_cnt); end
    checks++; if (exp_q.size() != 0 || busy !== 1'b0) begin failures++; $display("FAIL dllp_drain got left=%0d busy=%b expected 0/0", exp_q.size(), busy); end
  endtask

  task automatic test_tlp();
    int rdy_cnt = 0, tx_cnt = 0;
    exp_q.push_back({1'b1, K_STP});
    exp_q.push_back(9'h0AA); exp_q.push_back(9'h0BB); exp_q.push_back(9'h0CC);
    exp_q.push_back({1'b1, K_END});
    @(negedge pclk);
    tlp_src.push_back(9'h0AA); tlp_src.push_back(9'h0BB); tlp_src.push_back(9'h1CC);
    for (int i = 0; i < 20; i++) begin
      @(negedge pclk);
      if (tlp_ready) rdy_cnt++;
      if (tx_valid) tx_cnt++;
    end
    checks++; if (rdy_cnt !== 3) begin failures++; $display("FAIL tlp_ready_cycles got %0d expected 3", rdy_cnt); end
    checks++; if (tx_cnt !== 5) begin failures++; $display("FAIL tlp_length got %0d expected 5", tx_cnt); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL tlp_drain got left=%0d expected 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int tx_cnt = 0, first = -1, last = -1, rdy_cnt = 0;
    logic [47:0] d;
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 4; j++) begin
        d = {40'h1122334455, 8'(r * 4 + j)};
        push_dllp_exp(d);
      end
      exp_q.push_back({1'b1, K_STP});
      for (int b = 0; b < 3; b++) exp_q.push_back({1'b0, 8'(8'hA0 + r * 16 + b)});
      exp_q.push_back({1'b1, K_END});
    end
    @(negedge pclk);
    for (int k = 0; k < 8; k++) dllp_src.push_back({40'h1122334455, 8'(k)});
    for (int r = 0; r < 2; r++)
      for (int b = 0; b < 3; b++) tlp_src.push_back({(b == 2), 8'(8'hA0 + r * 16 + b)});
    for (int i = 0; i < 110; i++) begin
      @(negedge pclk);
      if (dllp_ready) rdy_cnt++;
      if (tx_valid) begin tx_cnt++; if (first < 0) first = i; last = i; end
    end
    checks++; if (tx_cnt !== 74) begin failures++; $display("FAIL b2b_length got %0d expected 74", tx_cnt); end
    checks++; if (last - first + 1 !== 74) begin failures++; $display("FAIL b2b_contiguous got span=%0d expected 74", last - first + 1); end
    checks++; if (rdy_cnt !== 8) begin failures++; $display("FAIL b2b_dllp_grants got %0d expected 8", rdy_cnt); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_drain got left=%0d expected 0", exp_q.size()); end
  endtask

  task automatic test_underrun();
    int err_cnt = 0, tx_cnt = 0;
    logic err_on_edb = 1'b0;
    exp_q.push_back({1'b1, K_STP});
    exp_q.push_back(9'h010); exp_q.push_back(9'h020);
    exp_q.push_back({1'b1, K_EDB});
    @(negedge pclk);
    tlp_src.push_back(9'h010); tlp_src.push_back(9'h020);
    for (int i = 0; i < 20; i++) begin
      @(negedge pclk);
      if (tx_valid) tx_cnt++;
      if (underrun_err) begin
        err_cnt++;
        if (tx_datak && tx_data == K_EDB) err_on_edb = 1'b1;
      end
    end
    checks++; if (err_cnt !== 1) begin failures++; $display("FAIL underrun_pulses got %0d expected 1", err_cnt); end
    checks++; if (err_on_edb !== 1'b1) begin failures++; $display("FAIL underrun_align got %b expected 1", err_on_edb); end
    checks++; if (tx_cnt !== 4) begin failures++; $display("FAIL underrun_length got %0d expected 4", tx_cnt); end
    checks++; if (busy !== 1'b0 || exp_q.size() != 0) begin failures++; $display("FAIL underrun_idle got busy=%b left=%0d expected 0/0", busy, exp_q.size()); end
  endtask

  task automatic test_retrain();
    int rdy_cnt = 0;
    bit seen = 0;
    push_dllp_exp(48'hA1A2A3A4A5A6);
    push_dllp_exp(48'hB1B2B3B4B5B6);
    @(negedge pclk);
    dllp_src.push_back(48'hA1A2A3A4A5A6);
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge pclk);
      if (dllp_ready) seen = 1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL retrain_first_grant got none expected grant"); end
    @(posedge pclk); #1;
    link_state = RETRAIN_state;
    @(negedge pclk);
    dllp_src.push_back(48'hB1B2B3B4B5B6);
    for (int i = 0; i < 20; i++) begin
      @(negedge pclk);
      if (dllp_ready) rdy_cnt++;
    end
    checks++; if (rdy_cnt !== 0) begin failures++; $display("FAIL retrain_no_grant got %0d expected 0", rdy_cnt); end
    checks++; if (exp_q.size() != 8 || busy !== 1'b0) begin failures++; $display("FAIL retrain_complete got left=%0d busy=%b expected 8/0", exp_q.size(), busy); end
    @(posedge pclk); #1;
    link_state = ACTIVE_state;
    for (int i = 0; i < 20; i++) begin
      @(negedge pclk);
      if (dllp_ready) rdy_cnt++;
    end
    checks++; if (rdy_cnt !== 1 || exp_q.size() != 0) begin failures++; $display("FAIL retrain_resume got grants=%0d left=%0d expected 1/0", rdy_cnt, exp_q.size()); end
  endtask

  task automatic test_link_reset();
    bit seen = 0;
    mon_en = 1'b0;
    @(negedge pclk);
    for (int b = 1; b <= 4; b++) tlp_src.push_back({(b == 4), 8'(b)});
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge pclk);
      if (tx_valid && tx_datak && tx_data == K_STP) seen = 1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL linkrst_start got none expected STP"); end
    @(posedge pclk); #1;
    link_state = RESET_state;
    @(negedge pclk);
    checks++; if (tlp_ready !== 1'b0) begin failures++; $display("FAIL linkrst_ready got %b expected 0", tlp_ready); end
    @(negedge pclk);
    checks++; if ({tx_valid, busy, tx_datak, tx_data} !== 11'd0) begin failures++; $display("FAIL linkrst_idle got %b/%b/%b/%h expected 0", tx_valid, busy, tx_datak, tx_data); end
    tlp_src.delete();
    @(posedge pclk); #1;
    link_state = ACTIVE_state;
    repeat (3) @(negedge pclk);
    mon_en = 1'b1;
  endtask

  task automatic test_l0s();
    @(posedge pclk); #1;
    link_state = RETRAIN_state;
    @(posedge pclk); #1;
    link_state = ACTIVE_state;
    repeat (63) @(posedge pclk);
    @(negedge pclk);
    checks++; if (l0s_req !== 1'b0) begin failures++; $display("FAIL l0s_early got %b expected 0", l0s_req); end
    @(negedge pclk);
    checks++; if (l0s_req !== 1'b1) begin failures++; $display("FAIL l0s_rise got %b expected 1", l0s_req); end
    push_dllp_exp(48'h0F0E0D0C0B0A);
    dllp_src.push_back(48'h0F0E0D0C0B0A);
    @(negedge pclk);
    checks++; if ({dllp_valid, dllp_ready, l0s_req} !== 3'b111) begin failures++; $display("FAIL l0s_valid_cycle got %b expected 111", {dllp_valid, dllp_ready, l0s_req}); end
    @(negedge pclk);
    checks++; if (l0s_req !== 1'b0) begin failures++; $display("FAIL l0s_fall got %b expected 0", l0s_req); end
    repeat (12) @(negedge pclk);
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL l0s_dllp_drain got left=%0d expected 0", exp_q.size()); end
  endtask

  task automatic test_async_reset();
    bit seen = 0;
    mon_en = 1'b0;
    @(negedge pclk);
    dllp_src.push_back(48'h123456789ABC);
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge pclk);
      if (tx_valid && tx_datak && tx_data == K_SDP) seen = 1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL arst_start got none expected SDP"); end
    @(posedge pclk); #3;
    checks++; if (tx_valid !== 1'b1) begin failures++; $display("FAIL arst_inflight got %b expected 1", tx_valid); end
    reset_n = 1'b0;
    #1;
    checks++; if ({tx_valid, tx_datak, tx_data, busy, underrun_err, dllp_ready, tlp_ready} !== 14'd0) begin
      failures++;
      $display("FAIL arst_outputs got %b/%b/%h/%b/%b/%b/%b expected 0", tx_valid, tx_datak, tx_data, busy, underrun_err, dllp_ready, tlp_ready);
    end
    @(posedge pclk); #1;
    reset_n = 1'b1;
    repeat (3) @(negedge pclk);
    checks++; if ({busy, tx_valid} !== 2'b00) begin failures++; $display("FAIL arst_after got %b expected 00", {busy, tx_valid}); end
  endtask

  initial begin
    fork
      lane_monitor();
      source_driver();
    join_none
    test_reset();
    test_single_dllp();
    test_tlp();
    test_back_to_back();
    test_underrun();
    test_retrain();
    test_link_reset();
    test_l0s();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
